// File: rtl/core_pkg.sv
// Shared definitions for the memory-stage data-bus master: FSM states,
// funct3 access-size encodings and a helper that maps funct3 to a size.
package core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_t;

  // Unused encodings (011/110/111) fall through to word accesses.
  function automatic access_size_t access_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      default:     return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/store_align.sv
// Byte-enable and lane-replication generator for data-bus accesses.
// Loads reuse the same byte-enable pattern as stores of the same size.
module store_align
  import core_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_offset,
  input  logic [31:0] store_data,
  output logic [3:0]  byte_en,
  output logic [31:0] lane_data
);

  always_comb begin
    byte_en   = 4'b1111;
    lane_data = store_data;
    case (access_size(funct3))
      SZ_BYTE: begin
        byte_en   = 4'b0001 << byte_offset;
        lane_data = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        byte_en   = 4'b0011 << byte_offset;
        lane_data = {2{store_data[15:0]}};
      end
      default: begin
        byte_en   = 4'b1111;
        lane_data = store_data;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_interface.sv
// Memory-stage data-bus master: issues aligned load/store transactions,
// stalls the pipeline until ack or timeout, and captures raw load data.
module data_mem_interface
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 10
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  output logic        DBusReq,
  output logic        DBusWe,
  output logic [31:0] DBusAddr,
  output logic [3:0]  DBusBE,
  output logic [31:0] DBusWData,
  input  logic        DBusAck,
  input  logic [31:0] DBusRData,
  output logic        StallM,
  output logic [31:0] ReadDataRawW,
  output logic [1:0]  ByteOffsetW,
  output logic [2:0]  Funct3W,
  output logic        MisalignM,
  output logic        BusErrM
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             access;
  logic             misaligned;
  logic             issue;
  logic [3:0]       be_next;
  logic [31:0]      wdata_next;

  assign access = MemReadM | MemWriteM;

  always_comb begin
    misaligned = 1'b0;
    case (access_size(Funct3M))
      SZ_HALF: misaligned = AddrM[0];
      SZ_WORD: misaligned = |AddrM[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // A misaligned access never reaches the bus; the pipeline traps instead.
  assign issue     = (state == ST_IDLE) && access && !misaligned;
  assign MisalignM = (state == ST_IDLE) && access && misaligned;
  assign StallM    = issue || (state == ST_BUSY);

  store_align u_store_align (
    .funct3      (Funct3M),
    .byte_offset (AddrM[1:0]),
    .store_data  (WriteDataM),
    .byte_en     (be_next),
    .lane_data   (wdata_next)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      DBusReq      <= 1'b0;
      DBusWe       <= 1'b0;
      DBusAddr     <= '0;
      DBusBE       <= '0;
      DBusWData    <= '0;
      ReadDataRawW <= '0;
      ByteOffsetW  <= '0;
      Funct3W      <= '0;
      BusErrM      <= 1'b0;
    end else begin
      BusErrM <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            DBusReq     <= 1'b1;
            DBusWe      <= MemWriteM;
            DBusAddr    <= {AddrM[31:2], 2'b00};
            DBusBE      <= be_next;
            DBusWData   <= wdata_next;
            ByteOffsetW <= AddrM[1:0];
            Funct3W     <= Funct3M;
            wait_cnt    <= '0;
            state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          wait_cnt <= wait_cnt + 1'b1;
          // An ack arriving on the final permitted cycle still completes normally.
          if (DBusAck) begin
            DBusReq <= 1'b0;
            if (!DBusWe) ReadDataRawW <= DBusRData;
            state <= ST_RESP;
          end else if (wait_cnt == CNT_LAST) begin
            DBusReq      <= 1'b0;
            BusErrM      <= 1'b1;
            ReadDataRawW <= '0;
            state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
